// File: rtl/ped_pkg.sv
// rtl/ped_pkg.sv - shared light codes, crosswalk state type and code legality check
package ped_pkg;

  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WALK  = 2'd1,
    FLASH = 2'd2,
    DONE  = 2'd3
  } xwalk_state_t;

  function automatic logic light_legal(input logic [2:0] code);
    return (code == LIGHT_RED) || (code == LIGHT_YEL) || (code == LIGHT_GRN);
  endfunction

endpackage

// File: rtl/ped_xwalk_fsm.sv
// rtl/ped_xwalk_fsm.sv - one crosswalk: request latch, walk/flash/done sequencing, registered lamps
module ped_xwalk_fsm
  import ped_pkg::*;
#(
  parameter int WALK_CYC  = 8,
  parameter int FLASH_CYC = 6,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             perm,
  input  logic             btn,
  input  logic             kill,
  output logic             walk,
  output logic             dontwalk,
  output logic [CNT_W-1:0] cnt,
  output logic             req,
  output logic             abort_p
);

  localparam int TMR_MAX = (WALK_CYC > FLASH_CYC) ? WALK_CYC : FLASH_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  xwalk_state_t     state, state_n;
  logic [TMR_W-1:0] tmr, tmr_n;
  logic             btn_q;
  logic             req_set, req_n, walk_n, dontwalk_n, abort_n;
  logic [CNT_W-1:0] cnt_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tmr      <= '0;
      btn_q    <= 1'b0;
      req      <= 1'b0;
      walk     <= 1'b0;
      dontwalk <= 1'b1;
      cnt      <= '0;
      abort_p  <= 1'b0;
    end else begin
      state    <= state_n;
      tmr      <= tmr_n;
      btn_q    <= btn;
      req      <= req_n;
      walk     <= walk_n;
      dontwalk <= dontwalk_n;
      cnt      <= cnt_n;
      abort_p  <= abort_n;
    end
  end

  always_comb begin
    state_n = state;
    tmr_n   = tmr;
    abort_n = 1'b0;
    // Rising edge only, so a held button latches a single request.
    req_set = btn && !btn_q && (state != WALK);
    req_n   = req | req_set;
    if (kill) begin
      state_n = IDLE;
      tmr_n   = '0;
      req_n   = 1'b0;
    end else begin
      case (state)
        IDLE: if (req && perm) begin
          state_n = WALK;
          tmr_n   = TMR_W'(WALK_CYC - 1);
          req_n   = req_set;
        end
        WALK: if (!perm) begin
          state_n = IDLE;
          abort_n = 1'b1;
        end else if (tmr == '0) begin
          state_n = FLASH;
          tmr_n   = TMR_W'(FLASH_CYC - 1);
        end else begin
          tmr_n = tmr - 1'b1;
        end
        FLASH: if (!perm) begin
          state_n = IDLE;
          abort_n = 1'b1;
        end else if (tmr == '0) begin
          state_n = DONE;
        end else begin
          tmr_n = tmr - 1'b1;
        end
        DONE: if (!perm) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
    walk_n     = (state_n == WALK);
    cnt_n      = (state_n == FLASH) ? CNT_W'(tmr_n) : '0;
    dontwalk_n = (state_n == FLASH && state == FLASH) ? !dontwalk : (state_n != WALK);
  end

endmodule

// File: rtl/ped_crossing_ctrl.sv
// rtl/ped_crossing_ctrl.sv - permission decode, sticky fault detection and two crosswalk FSMs
module ped_crossing_ctrl
  import ped_pkg::*;
#(
  parameter int WALK_CYC  = 8,
  parameter int FLASH_CYC = 6,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       north_light,
  input  logic [2:0]       south_light,
  input  logic [2:0]       east_light,
  input  logic [2:0]       west_light,
  input  logic             btn_a,
  input  logic             btn_b,
  output logic             walk_a,
  output logic             walk_b,
  output logic             dontwalk_a,
  output logic             dontwalk_b,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic             req_a,
  output logic             req_b,
  output logic             abort,
  output logic             fault
);

  logic perm_a, perm_b, illegal, abort_a, abort_b;

  assign perm_a  = (east_light == LIGHT_RED) && (west_light == LIGHT_RED);
  assign perm_b  = (north_light == LIGHT_RED) && (south_light == LIGHT_RED);
  assign illegal = !light_legal(north_light) || !light_legal(south_light) ||
                   !light_legal(east_light)  || !light_legal(west_light);

  always_ff @(posedge clk) begin
    if (rst) fault <= 1'b0;
    else     fault <= fault | illegal;
  end

  // Both abort sources are registered, so the OR adds no input-to-output path.
  assign abort = abort_a | abort_b;

  ped_xwalk_fsm #(.WALK_CYC(WALK_CYC), .FLASH_CYC(FLASH_CYC), .CNT_W(CNT_W)) u_xwalk_a (
    .clk(clk), .rst(rst), .perm(perm_a), .btn(btn_a), .kill(fault),
    .walk(walk_a), .dontwalk(dontwalk_a), .cnt(cnt_a), .req(req_a), .abort_p(abort_a)
  );

  ped_xwalk_fsm #(.WALK_CYC(WALK_CYC), .FLASH_CYC(FLASH_CYC), .CNT_W(CNT_W)) u_xwalk_b (
    .clk(clk), .rst(rst), .perm(perm_b), .btn(btn_b), .kill(fault),
    .walk(walk_b), .dontwalk(dontwalk_b), .cnt(cnt_b), .req(req_b), .abort_p(abort_b)
  );

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// tb/tb_ped_crossing_ctrl.sv - randomized light/button stimulus checked against a grant-age reference model
module tb_ped_crossing_ctrl;

  localparam int W = 8;
  localparam int F = 6;
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] north_light, south_light, east_light, west_light;
  logic       btn_a, btn_b;
  logic       walk_a, walk_b, dontwalk_a, dontwalk_b, req_a, req_b, abort, fault;
  logic [3:0] cnt_a, cnt_b;

  ped_crossing_ctrl #(.WALK_CYC(W), .FLASH_CYC(F), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .north_light(north_light), .south_light(south_light),
    .east_light(east_light), .west_light(west_light),
    .btn_a(btn_a), .btn_b(btn_b),
    .walk_a(walk_a), .walk_b(walk_b), .dontwalk_a(dontwalk_a), .dontwalk_b(dontwalk_b),
    .cnt_a(cnt_a), .cnt_b(cnt_b), .req_a(req_a), .req_b(req_b),
    .abort(abort), .fault(fault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
  endtask

  // Reference: a granted crosswalk is described by its age since grant.
  bit m_act[2], m_done[2], m_req[2], m_bprev[2];
  int m_age[2];
  bit m_abort, m_fault;

  function automatic bit legal(input logic [2:0] c);
    return c == RED || c == YEL || c == GRN;
  endfunction

  task automatic model_edge(input bit r, input logic [2:0] n, s, e, w, input bit ba, bb);
    bit perm[2], btn[2], rise, grant, in_walk, ill;
    if (r) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] = 0; m_done[i] = 0; m_req[i] = 0; m_bprev[i] = 0; m_age[i] = 0;
      end
      m_abort = 0; m_fault = 0;
      return;
    end
    perm[0] = (e == RED) && (w == RED);
    perm[1] = (n == RED) && (s == RED);
    btn[0] = ba; btn[1] = bb;
    ill = !legal(n) || !legal(s) || !legal(e) || !legal(w);
    m_abort = 0;
    for (int i = 0; i < 2; i++) begin
      rise = btn[i] && !m_bprev[i];
      m_bprev[i] = btn[i];
      if (m_fault) begin
        m_act[i] = 0; m_done[i] = 0; m_req[i] = 0;
        continue;
      end
      in_walk = m_act[i] && m_age[i] < W;
      grant = !m_act[i] && !m_done[i] && m_req[i] && perm[i];
      if (rise && in_walk) rise = 0;
      if (m_act[i]) begin
        if (!perm[i]) begin
          m_act[i] = 0; m_abort = 1;
        end else begin
          m_age[i]++;
          if (m_age[i] == W + F) begin m_act[i] = 0; m_done[i] = 1; end
        end
      end else if (m_done[i]) begin
        if (!perm[i]) m_done[i] = 0;
      end else if (grant) begin
        m_act[i] = 1; m_age[i] = 0;
      end
      m_req[i] = grant ? rise : (m_req[i] | rise);
    end
    m_fault = m_fault | ill;
  endtask

  task automatic compare_all();
    int fl, ew;
    for (int i = 0; i < 2; i++) begin
      bit wk, fs;
      int ec, ed;
      wk = m_act[i] && m_age[i] < W;
      fs = m_act[i] && m_age[i] >= W;
      fl = m_age[i] - W;
      ec = fs ? (F - 1 - fl) : 0;
      ed = !wk && (!fs || (fl % 2 == 0));
      if (i == 0) begin
        check("walk_a", walk_a, wk); check("dontwalk_a", dontwalk_a, ed);
        check("cnt_a", cnt_a, ec);   check("req_a", req_a, m_req[0]);
      end else begin
        check("walk_b", walk_b, wk); check("dontwalk_b", dontwalk_b, ed);
        check("cnt_b", cnt_b, ec);   check("req_b", req_b, m_req[1]);
      end
    end
    ew = 0;
    check("abort", abort, m_abort);
    check("fault", fault, m_fault);
  endtask

  task automatic step(input bit r, input logic [2:0] n, s, e, w, input bit ba, bb);
    rst = r; north_light = n; south_light = s; east_light = e; west_light = w;
    btn_a = ba; btn_b = bb;
    @(posedge clk);
    model_edge(r, n, s, e, w, ba, bb);
    #1;
    compare_all();
  endtask

  function automatic logic [2:0] rand_code();
    case ($urandom_range(0, 2))
      0:       return RED;
      1:       return YEL;
      default: return GRN;
    endcase
  endfunction

  function automatic logic [2:0] rand_illegal();
    case ($urandom_range(0, 4))
      0:       return 3'b000;
      1:       return 3'b011;
      2:       return 3'b101;
      3:       return 3'b110;
      default: return 3'b111;
    endcase
  endfunction

  initial begin
    logic [2:0] ew, ns, n, s, e, w;
    bit ba, bb, r;

    // Directed: E/W red, single btn_a pulse, full walk/flash/done sequence.
    step(1, GRN, GRN, RED, RED, 0, 0);
    step(1, GRN, GRN, RED, RED, 0, 0);
    for (int c = 0; c < 4; c++) step(0, GRN, GRN, RED, RED, 0, 0);
    step(0, GRN, GRN, RED, RED, 1, 0);
    for (int c = 0; c < 20; c++) step(0, GRN, GRN, RED, RED, 0, 0);
    // Button while E green, then E/W go red.
    step(0, RED, RED, GRN, GRN, 1, 0);
    for (int c = 0; c < 3; c++) step(0, RED, RED, GRN, GRN, 0, 0);
    for (int c = 0; c < 4; c++) step(0, RED, RED, RED, RED, 0, 0);
    // Perm loss mid-walk, then all red with both buttons in lockstep.
    step(0, RED, RED, GRN, RED, 0, 0);
    for (int c = 0; c < 2; c++) step(0, YEL, YEL, YEL, YEL, 0, 0);
    step(0, RED, RED, RED, RED, 1, 1);
    for (int c = 0; c < 16; c++) step(0, RED, RED, RED, RED, 0, 0);
    // Illegal north code then buttons ignored.
    step(0, 3'b110, RED, RED, RED, 0, 0);
    for (int c = 0; c < 5; c++) step(0, RED, RED, RED, RED, c[0], c[0]);

    for (int ep = 0; ep < 6; ep++) begin
      step(1, GRN, GRN, RED, RED, 0, 0);
      ew = RED; ns = GRN; ba = 0; bb = 0;
      for (int c = 0; c < 300; c++) begin
        if ($urandom_range(0, 39) == 0) ew = rand_code();
        if ($urandom_range(0, 39) == 0) ns = rand_code();
        e = ew; w = ew; n = ns; s = ns;
        if ($urandom_range(0, 40) == 0) w = rand_code();
        if ($urandom_range(0, 40) == 0) s = rand_code();
        if ($urandom_range(0, 5) == 0) ba = !ba;
        if ($urandom_range(0, 5) == 0) bb = !bb;
        if (ep == 3 && c == 120) n = rand_illegal();
        if (ep == 4 && c == 90) e = rand_illegal();
        r = (ep == 2 && (c == 100 || c == 200));
        step(r, n, s, e, w, ba, bb);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
